// File: rtl/alu_sched_pkg.sv
// Shared opcode constants, FSM state type and opcode legality helper for the ALU request scheduler.
package alu_sched_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_CRC = 4'h4;
  localparam logic [3:0] OP_NOP = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Requests that must be answered with an error instead of reaching the ALU.
  function automatic logic op_is_err(input logic [3:0] op, input logic b_zero);
    return (op > OP_CRC) || ((op == OP_DIV) && b_zero);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or above rr_ptr, wrapping around.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[IW'(idx)]) begin
        found            = 1'b1;
        grant[IW'(idx)]  = 1'b1;
        grant_idx        = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU between NUM_REQ requesters: round-robin grant, timed issue, captured response.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DW-1:0]      req_a,
  input  logic [NUM_REQ*DW-1:0]      req_b,
  input  logic [NUM_REQ*4-1:0]       req_op,
  output logic [DW-1:0]              alu_a,
  output logic [DW-1:0]              alu_b,
  output logic [3:0]                 alu_opcode,
  input  logic [DW-1:0]              alu_result,
  input  logic [DW-1:0]              alu_crc,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [DW-1:0]              resp_result,
  output logic [DW-1:0]              resp_crc,
  output logic                       resp_err,
  output logic                       busy
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t              state;
  logic [IW-1:0]       rr_ptr;
  logic [CW-1:0]       cnt;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [IW-1:0]       arb_idx;
  logic [DW-1:0]       sel_a;
  logic [DW-1:0]       sel_b;
  logic [3:0]          sel_op;
  logic                sel_err;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Payload of the requester the arbiter would grant this cycle.
  always_comb begin
    sel_a   = req_a[32'(arb_idx) * DW +: DW];
    sel_b   = req_b[32'(arb_idx) * DW +: DW];
    sel_op  = req_op[32'(arb_idx) * 4 +: 4];
    sel_err = op_is_err(sel_op, sel_b == '0);
  end

  // Accept pulse only while idle; held off during reset so every output reads 0.
  assign req_ready = (rst_n && (state == IDLE)) ? arb_grant : '0;

  // The ALU operand registers double as the request latches, so the ALU sees
  // a complete operand set from the cycle after the accept edge onward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= OP_NOP;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_crc    <= '0;
      resp_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            busy    <= 1'b1;
            resp_id <= arb_idx;
            if (sel_err) begin
              state       <= RESP;
              resp_valid  <= 1'b1;
              resp_err    <= 1'b1;
              resp_result <= '0;
              resp_crc    <= '0;
            end else begin
              state      <= ISSUE;
              alu_a      <= sel_a;
              alu_b      <= sel_b;
              alu_opcode <= sel_op;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= CW'(ALU_LAT - 1);
        end
        WAIT: begin
          if (cnt == '0) begin
            state       <= RESP;
            resp_valid  <= 1'b1;
            resp_err    <= 1'b0;
            resp_result <= alu_result;
            resp_crc    <= alu_crc;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= OP_NOP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            rr_ptr     <= (resp_id == IW'(NUM_REQ - 1)) ? '0 : resp_id + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed and randomized checks of alu_req_scheduler against a transaction-level reference model.
module tb_alu_req_scheduler;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int LAT = 1;
  localparam logic [3:0] NOP = 4'hF;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a;
  logic [N*DW-1:0]   req_b;
  logic [N*4-1:0]    req_op;
  logic [DW-1:0]     alu_a, alu_b, alu_result, alu_crc;
  logic [3:0]        alu_opcode;
  logic              resp_valid, resp_ready, resp_err, busy;
  logic [1:0]        resp_id;
  logic [DW-1:0]     resp_result, resp_crc;

  always #5 clk = ~clk;

  alu_req_scheduler #(.NUM_REQ(N), .DW(DW), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_crc(alu_crc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_crc(resp_crc), .resp_err(resp_err),
    .busy(busy)
  );

  // Behavioural ALU with a LAT-deep registered output.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a * b;
      4'h3:    return (b != 0) ? a / b : 32'hFFFF_FFFF;
      4'h4:    return a ^ ~b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] crc_fn(input logic [31:0] r);
    return {r[15:0], r[31:16]} ^ 32'h04C1_1DB7;
  endfunction

  logic [31:0] pr [LAT];
  logic [31:0] pc [LAT];
  always @(posedge clk) begin
    pr[0] <= alu_fn(alu_a, alu_b, alu_opcode);
    pc[0] <= crc_fn(alu_fn(alu_a, alu_b, alu_opcode));
    for (int i = 1; i < LAT; i++) begin
      pr[i] <= pr[i-1];
      pc[i] <= pc[i-1];
    end
  end
  assign alu_result = pr[LAT-1];
  assign alu_crc    = pc[LAT-1];

  // Reference model state
  txn_t        q [N][$];
  logic [N-1:0] en;
  bit          rand_en, rand_ready, stall;
  int          total, bad, cyc;
  bit          busy_m, g_err, seen;
  int          ptr_m, g_id, g_cyc, due, lat_first, pop_idx;
  txn_t        g_t;
  logic [31:0] exp_res, exp_crc;
  int          grant_log[$];
  logic [31:0] res_log[$];
  logic        err_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      en[i] = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (q[i].size() > 0) begin
        req_valid[i]        = en[i];
        req_a[i*DW +: DW]   = q[i][0].a;
        req_b[i*DW +: DW]   = q[i][0].b;
        req_op[i*4 +: 4]    = q[i][0].op;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    resp_ready = stall ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_op"}, alu_opcode, NOP);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_id"}, resp_id, 0);
    chk({tag, "_resp_result"}, resp_result, 0);
    chk({tag, "_resp_crc"}, resp_crc, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // One clock: check outputs at the falling edge, update inputs just after the rising edge.
  task automatic step();
    bit           b0;
    int           e, idx;
    logic [N-1:0] rv, rdy, exp_rdy;
    @(negedge clk);
    cyc++;
    b0  = busy_m;
    rv  = req_valid;
    rdy = req_ready;
    chk("busy", busy, b0);
    if (b0 && !g_err && cyc > g_cyc && cyc <= g_cyc + LAT + 1) begin
      chk("alu_opcode", alu_opcode, g_t.op);
      chk("alu_a", alu_a, g_t.a);
      chk("alu_b", alu_b, g_t.b);
    end else begin
      chk("alu_nop", alu_opcode, NOP);
    end
    if (b0) begin
      if (cyc < due) begin
        chk("resp_early", resp_valid, 0);
      end else begin
        if (resp_valid && !seen) begin
          seen      = 1;
          lat_first = cyc - g_cyc;
        end
        chk("resp_valid", resp_valid, 1);
        chk("resp_id", resp_id, g_id);
        chk("resp_result", resp_result, exp_res);
        chk("resp_crc", resp_crc, exp_crc);
        chk("resp_err", resp_err, g_err);
        if (resp_valid && resp_ready) begin
          res_log.push_back(resp_result);
          err_log.push_back(resp_err);
          busy_m = 0;
          ptr_m  = (g_id + 1) % N;
        end
      end
    end else begin
      chk("resp_idle", resp_valid, 0);
    end
    if (!b0) begin
      e = -1;
      for (int k = 0; k < N; k++) begin
        idx = (ptr_m + k) % N;
        if (e < 0 && rv[idx]) e = idx;
      end
      exp_rdy = '0;
      if (e >= 0) exp_rdy[e] = 1'b1;
      chk("grant", rdy, exp_rdy);
      if (e >= 0) begin
        busy_m  = 1;
        seen    = 0;
        g_id    = e;
        g_t     = q[e][0];
        g_cyc   = cyc;
        g_err   = (g_t.op > 4'h4) || (g_t.op == 4'h3 && g_t.b == 0);
        due     = cyc + (g_err ? 1 : LAT + 2);
        exp_res = g_err ? 32'h0 : alu_fn(g_t.a, g_t.b, g_t.op);
        exp_crc = g_err ? 32'h0 : crc_fn(alu_fn(g_t.a, g_t.b, g_t.op));
        grant_log.push_back(e);
        pop_idx = e;
      end
    end else begin
      chk("grant_busy", rdy, 0);
    end
    @(posedge clk);
    #1;
    if (pop_idx >= 0) begin
      void'(q[pop_idx].pop_front());
      pop_idx = -1;
    end
    drive_inputs();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    bit pend;
    n = 0;
    pend = busy_m;
    for (int i = 0; i < N; i++) if (q[i].size() > 0) pend = 1;
    while (pend && n < budget) begin
      step();
      n++;
      pend = busy_m;
      for (int i = 0; i < N; i++) if (q[i].size() > 0) pend = 1;
    end
    chk("drain_budget", pend, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    busy_m = 0;
    ptr_m  = 0;
    rst_n  = 1'b1;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    res_log.delete();
    err_log.delete();
  endtask

  function automatic txn_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    txn_t t;
    t.a = a; t.b = b; t.op = op;
    return t;
  endfunction

  int exp3 [5] = '{0, 1, 2, 3, 0};

  initial begin
    txn_t t;
    int   r;
    total = 0; bad = 0; cyc = 0;
    busy_m = 0; ptr_m = 0; pop_idx = -1; seen = 0;
    g_cyc = 0; due = 0; g_id = 0; g_err = 0; lat_first = 0;
    rand_en = 0; rand_ready = 0; stall = 0;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("init");
    rst_n = 1'b1;
    drive_inputs();

    // 1: single ADD from requester 0
    clear_logs();
    q[0].push_back(mk(32'h15, 32'h0A, 4'h0));
    drive_inputs();
    run_until_idle(50);
    chk("t1_count", res_log.size(), 1);
    if (res_log.size() == 1) chk("t1_result", res_log[0], 32'h1F);
    chk("t1_latency", lat_first, 3);
    chk("t1_id", grant_log[0], 0);

    // 2: SUB, MUL, DIV back to back from requester 1
    clear_logs();
    q[1].push_back(mk(32'h15, 32'h0A, 4'h1));
    q[1].push_back(mk(32'h3, 32'h4, 4'h2));
    q[1].push_back(mk(32'h10, 32'h4, 4'h3));
    drive_inputs();
    run_until_idle(100);
    chk("t2_count", res_log.size(), 3);
    if (res_log.size() == 3) begin
      chk("t2_sub", res_log[0], 32'h0B);
      chk("t2_mul", res_log[1], 32'h0C);
      chk("t2_div", res_log[2], 32'h04);
    end

    // 3: all four requesting at once, fair rotation from 0
    do_reset();
    clear_logs();
    q[0].push_back(mk(32'h1, 32'h1, 4'h0));
    q[0].push_back(mk(32'h5, 32'h5, 4'h0));
    for (int i = 1; i < N; i++) q[i].push_back(mk(32'(i), 32'h100, 4'h0));
    drive_inputs();
    run_until_idle(200);
    chk("t3_count", grant_log.size(), 5);
    if (grant_log.size() == 5)
      for (int i = 0; i < 5; i++) chk("t3_order", grant_log[i], exp3[i]);

    // 4: divide by zero from requester 2
    clear_logs();
    q[2].push_back(mk(32'h10, 32'h0, 4'h3));
    drive_inputs();
    run_until_idle(50);
    chk("t4_count", err_log.size(), 1);
    if (err_log.size() == 1) begin
      chk("t4_err", err_log[0], 1);
      chk("t4_result", res_log[0], 0);
    end

    // 5: illegal opcode from requester 3, response back-pressured; requester 0 waits
    clear_logs();
    stall = 1;
    q[3].push_back(mk(32'h7, 32'h9, 4'h5));
    q[0].push_back(mk(32'h2, 32'h3, 4'h0));
    drive_inputs();
    repeat (7) step();
    chk("t5_latency", lat_first, 1);
    chk("t5_err_held", resp_err, 1);
    chk("t5_id_held", resp_id, 3);
    chk("t5_grants", grant_log.size(), 1);
    stall = 0;
    drive_inputs();
    run_until_idle(50);
    chk("t5_next", grant_log[grant_log.size()-1], 0);

    // 6: reset while the ALU is busy
    clear_logs();
    q[1].push_back(mk(32'h20, 32'h3, 4'h2));
    q[3].push_back(mk(32'h8, 32'h8, 4'h0));
    drive_inputs();
    r = 0;
    while (!(busy_m && cyc == g_cyc + 1) && r < 20) begin step(); r++; end
    chk("t6_in_wait", alu_opcode, g_t.op);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6");
    busy_m = 0;
    ptr_m  = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_no_resp", resp_valid, 0);
    q[0].push_back(mk(32'h4, 32'h4, 4'h1));
    clear_logs();
    rst_n = 1'b1;
    drive_inputs();
    run_until_idle(100);
    chk("t6_first_grant", grant_log[0], 0);

    // Random traffic: all opcodes, withdrawals, random response back-pressure
    rand_en = 1;
    rand_ready = 1;
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < 8; j++) begin
          r = int'($urandom_range(0, 9));
          t.op = (r < 8) ? 4'(r % 5) : 4'($urandom_range(5, 15));
          t.a  = $urandom;
          t.b  = (t.op == 4'h3 && $urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
          q[i].push_back(t);
        end
      end
      drive_inputs();
      run_until_idle(3000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
